// File: rtl/tristate_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tristate_bus_scheduler
// Brief   : Round-robin owner scheduler for a shared bufif1 tri-state bus.
//           Grants one driver at a time, caps ownership at MAX_HOLD cycles
//           and inserts GUARD_CYCLES of dead time between successive owners.
// Revision: 1.0 - initial release
// ============================================================================
module tristate_bus_scheduler #(
    parameter int N            = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_HOLD     = 8,
    parameter int IDW          = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   oe,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           in_guard,
    output logic           timeout
);

    localparam int c_HCW = 16;
    localparam int c_GCW = 4;
    localparam int c_JW  = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GUARD = 2'b10
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_oe;
    logic [IDW-1:0]     r_owner;
    logic               r_busy;
    logic               r_in_guard;
    logic               r_timeout;
    logic [IDW-1:0]     r_rr_ptr;
    logic [c_HCW-1:0]   r_hold_cnt;
    logic [c_GCW-1:0]   r_guard_cnt;

    state_t             w_state_nxt;
    logic [N-1:0]       w_oe_nxt;
    logic [IDW-1:0]     w_owner_nxt;
    logic               w_busy_nxt;
    logic               w_in_guard_nxt;
    logic               w_timeout_nxt;
    logic [IDW-1:0]     w_rr_nxt;
    logic [c_HCW-1:0]   w_hold_nxt;
    logic [c_GCW-1:0]   w_guard_nxt;

    logic               w_win_vld;
    logic [IDW-1:0]     w_win_idx;
    logic [c_JW-1:0]    w_cand;
    logic [N-1:0]       w_win_oh;
    logic               w_own_req;
    logic               w_at_limit;
    logic               w_release;
    logic [IDW-1:0]     w_owner_inc;

    // Round-robin search: descending loop so the nearest candidate to rr_ptr wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_rr_ptr} + c_JW'(i);
            if (w_cand >= c_JW'(N)) begin
                w_cand = w_cand - c_JW'(N);
            end
            if (req[w_cand[IDW-1:0]]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand[IDW-1:0];
            end
        end
    end

    assign w_win_oh    = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_own_req   = req[r_owner];
    assign w_at_limit  = (MAX_HOLD != 0) && (r_hold_cnt == c_HCW'(MAX_HOLD));
    assign w_release   = !w_own_req || !en || w_at_limit;
    assign w_owner_inc = (r_owner == IDW'(N - 1)) ? '0 : r_owner + IDW'(1);

    // Next-state and registered-output computation for IDLE/DRIVE/GUARD.
    always_comb begin
        w_state_nxt    = r_state;
        w_oe_nxt       = r_oe;
        w_owner_nxt    = r_owner;
        w_busy_nxt     = r_busy;
        w_in_guard_nxt = r_in_guard;
        w_timeout_nxt  = 1'b0;
        w_rr_nxt       = r_rr_ptr;
        w_hold_nxt     = r_hold_cnt;
        w_guard_nxt    = r_guard_cnt;
        case (r_state)
            ST_IDLE: begin
                if (en && w_win_vld) begin
                    w_state_nxt = ST_DRIVE;
                    w_oe_nxt    = w_win_oh;
                    w_owner_nxt = w_win_idx;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = c_HCW'(1);
                end
            end
            ST_DRIVE: begin
                if (w_release) begin
                    w_state_nxt    = ST_GUARD;
                    w_oe_nxt       = '0;
                    w_busy_nxt     = 1'b0;
                    w_in_guard_nxt = 1'b1;
                    w_rr_nxt       = w_owner_inc;
                    w_guard_nxt    = c_GCW'(GUARD_CYCLES - 1);
                    // A limit release only counts as a timeout if the owner still wanted the bus.
                    w_timeout_nxt  = w_at_limit && w_own_req && en;
                end else if (r_hold_cnt != '1) begin
                    w_hold_nxt = r_hold_cnt + c_HCW'(1);
                end
            end
            ST_GUARD: begin
                if (r_guard_cnt != '0) begin
                    w_guard_nxt = r_guard_cnt - c_GCW'(1);
                end else if (en && w_win_vld) begin
                    w_state_nxt    = ST_DRIVE;
                    w_oe_nxt       = w_win_oh;
                    w_owner_nxt    = w_win_idx;
                    w_busy_nxt     = 1'b1;
                    w_in_guard_nxt = 1'b0;
                    w_hold_nxt     = c_HCW'(1);
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_in_guard_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_oe_nxt       = '0;
                w_busy_nxt     = 1'b0;
                w_in_guard_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every driver enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_oe        <= '0;
            r_owner     <= '0;
            r_busy      <= 1'b0;
            r_in_guard  <= 1'b0;
            r_timeout   <= 1'b0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
            r_guard_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_oe        <= w_oe_nxt;
            r_owner     <= w_owner_nxt;
            r_busy      <= w_busy_nxt;
            r_in_guard  <= w_in_guard_nxt;
            r_timeout   <= w_timeout_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_guard_cnt <= w_guard_nxt;
        end
    end

    assign oe       = r_oe;
    assign owner    = r_owner;
    assign busy     = r_busy;
    assign in_guard = r_in_guard;
    assign timeout  = r_timeout;

    a_oe_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_oe));
    a_busy_oe:    assert property (@(posedge clk) disable iff (!rst_n) r_busy == (|r_oe));
    a_guard_off:  assert property (@(posedge clk) disable iff (!rst_n) r_in_guard |-> (r_oe == '0));

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_tristate_bus_scheduler
// Brief   : Directed vector bench for tristate_bus_scheduler (N=4, GUARD=2,
//           MAX_HOLD=8), plus a hand-written asynchronous reset sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tristate_bus_scheduler;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       in_guard;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rstn;
        logic       en;
        logic [3:0] req;
        logic [3:0] oe;
        logic [1:0] own;
        logic       busy;
        logic       grd;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    tristate_bus_scheduler #(
        .N(4), .GUARD_CYCLES(2), .MAX_HOLD(8), .IDW(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .oe(oe),
        .owner(owner), .busy(busy), .in_guard(in_guard), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rs, logic e, logic [3:0] r, logic [3:0] o,
                                logic [1:0] ow, logic b, logic g, logic t);
        vec_t v;
        v.rstn = rs; v.en = e; v.req = r; v.oe = o;
        v.own = ow; v.busy = b; v.grd = g; v.to = t;
        return v;
    endfunction

    function automatic void rs();
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    endfunction
    function automatic void dr(logic e, logic [3:0] r, logic [3:0] o, logic [1:0] ow);
        tbl.push_back(mk(1'b1, e, r, o, ow, 1'b1, 1'b0, 1'b0));
    endfunction
    function automatic void gd(logic e, logic [3:0] r, logic t);
        tbl.push_back(mk(1'b1, e, r, 4'h0, 2'd0, 1'b0, 1'b1, t));
    endfunction
    function automatic void id(logic e, logic [3:0] r);
        tbl.push_back(mk(1'b1, e, r, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    endfunction

    task automatic check(input vec_t v, input string tag);
        logic bad;
        n_vec++;
        bad = (oe !== v.oe) || (busy !== v.busy) || (in_guard !== v.grd) ||
              (timeout !== v.to) || ((v.busy || !v.rstn) && (owner !== v.own));
        if (bad) begin
            n_err++;
            $display("FAIL %s: got oe=%b owner=%0d busy=%b in_guard=%b timeout=%b, want oe=%b owner=%0d busy=%b in_guard=%b timeout=%b",
                     tag, oe, owner, busy, in_guard, timeout, v.oe, v.own, v.busy, v.grd, v.to);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n = v.rstn;
        en    = v.en;
        req   = v.req;
        @(posedge clk);
        #1;
        check(v, tag);
    endtask

    // Bus-safety invariants watched on every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!$onehot0(oe) || (busy !== (|oe)) || (in_guard && (oe != 4'h0))) begin
                n_err++;
                $display("FAIL invariant: oe=%b busy=%b in_guard=%b", oe, busy, in_guard);
            end
        end
    end

    initial begin
        logic [3:0] oh;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'h0;

        // Single grant, then release and guard, then IDLE.
        rs();
        repeat (4) dr(1'b1, 4'b0001, 4'b0001, 2'd0);
        gd(1'b1, 4'b0000, 1'b0);
        gd(1'b1, 4'b0000, 1'b0);
        id(1'b1, 4'b0000);

        // Round robin over four requesters, each dropping after 3 DRIVE cycles.
        rs();
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            repeat (3) dr(1'b1, 4'b1111, oh, 2'(k));
            gd(1'b1, 4'b1111 & ~oh, 1'b0);
            gd(1'b1, 4'b1111, 1'b0);
        end
        dr(1'b1, 4'b1111, 4'b0001, 2'd0);

        // Sole requester times out twice, 10 cycles apart.
        rs();
        repeat (8) dr(1'b1, 4'b0010, 4'b0010, 2'd1);
        gd(1'b1, 4'b0010, 1'b1);
        gd(1'b1, 4'b0010, 1'b0);
        repeat (8) dr(1'b1, 4'b0010, 4'b0010, 2'd1);
        gd(1'b1, 4'b0010, 1'b1);
        gd(1'b1, 4'b0010, 1'b0);
        id(1'b1, 4'b0000);

        // Timeout fairness: owner 0 times out, owner 1 is next.
        rs();
        repeat (8) dr(1'b1, 4'b0011, 4'b0001, 2'd0);
        gd(1'b1, 4'b0011, 1'b1);
        gd(1'b1, 4'b0011, 1'b0);
        repeat (2) dr(1'b1, 4'b0011, 4'b0010, 2'd1);

        // Request drop coinciding with the limit is a normal release.
        rs();
        repeat (8) dr(1'b1, 4'b0001, 4'b0001, 2'd0);
        gd(1'b1, 4'b0000, 1'b0);
        gd(1'b1, 4'b0000, 1'b0);
        id(1'b1, 4'b0000);

        // Enable abort mid-DRIVE, no grants while disabled, grant once enabled.
        rs();
        repeat (2) dr(1'b1, 4'b0100, 4'b0100, 2'd2);
        gd(1'b0, 4'b0100, 1'b0);
        gd(1'b0, 4'b0100, 1'b0);
        id(1'b0, 4'b1111);
        id(1'b0, 4'b1111);
        dr(1'b1, 4'b1111, 4'b1000, 2'd3);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-DRIVE with rr_ptr previously moved to 2.
        apply(mk(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0), "ar_reset");
        apply(mk(1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0), "ar_grant1");
        apply(mk(1'b1, 1'b1, 4'b0000, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0), "ar_rel");
        apply(mk(1'b1, 1'b1, 4'b0000, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0), "ar_guard");
        apply(mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0), "ar_grant2");
        apply(mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0), "ar_hold2");
        #2;
        rst_n = 1'b0;
        #1;
        check(mk(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0), "ar_async_drop");
        @(negedge clk);
        en  = 1'b1;
        req = 4'b1010;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(mk(1'b1, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0), "ar_regrant_ptr0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
